// File: rtl/audio_post.sv
// Audio post-processing: decimating DC-blocker, volume scaling with saturation,
// and mute, emitting a one-cycle strobe with each new stereo sample.
module audio_post #(
    parameter int DIV   = 1024,
    parameter int SHIFT = 8
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic signed [18:0] sound_mix,
    input  logic        [1:0]  vol,
    input  logic               mute,
    output logic               sample,
    output logic signed [15:0] aud_l,
    output logic signed [15:0] aud_r,
    output logic               clip
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0]      cnt;
    logic               tick;
    logic signed [23:0] x_prev;
    logic signed [23:0] y_prev;
    logic signed [23:0] x_ext;
    logic signed [25:0] y_sum;
    logic signed [23:0] y_next;
    logic signed [23:0] y_shift;
    logic signed [23:0] s_shift;
    logic signed [15:0] s_next;
    logic               clip_next;
    logic signed [15:0] s_reg;
    logic               clip_int;
    logic               v1;
    logic               v2;

    assign tick = (cnt == LAST);

    // Two guard bits keep the filter sum exact so saturation sees the true value.
    always_comb begin
        x_ext   = {{5{sound_mix[18]}}, sound_mix};
        y_shift = y_prev >>> SHIFT;
        y_sum   = {{2{x_ext[23]}}, x_ext} - {{2{x_prev[23]}}, x_prev}
                + {{2{y_prev[23]}}, y_prev} - {{2{y_shift[23]}}, y_shift};
        y_next  = y_sum[23:0];
        if (y_sum > 26'sd8388607) begin
            y_next = 24'sh7FFFFF;
        end else if (y_sum < -26'sd8388608) begin
            y_next = 24'sh800000;
        end
    end

    always_comb begin
        s_shift   = y_prev >>> (2'd3 - vol);
        s_next    = s_shift[15:0];
        clip_next = 1'b0;
        if (s_shift > 24'sd32767) begin
            s_next    = 16'sh7FFF;
            clip_next = 1'b1;
        end else if (s_shift < -24'sd32768) begin
            s_next    = 16'sh8000;
            clip_next = 1'b1;
        end
    end

    // v1/v2 carry a tick down the pipeline; reset clears them so no stale strobe escapes.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            x_prev   <= '0;
            y_prev   <= '0;
            v1       <= 1'b0;
            v2       <= 1'b0;
            s_reg    <= '0;
            clip_int <= 1'b0;
            aud_l    <= '0;
            aud_r    <= '0;
            clip     <= 1'b0;
            sample   <= 1'b0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            v1  <= tick;
            v2  <= v1;
            if (tick) begin
                x_prev <= x_ext;
                y_prev <= y_next;
            end
            if (v1) begin
                s_reg    <= s_next;
                clip_int <= clip_next;
            end
            sample <= v2;
            if (v2) begin
                aud_l <= mute ? 16'sd0 : s_reg;
                aud_r <= mute ? 16'sd0 : s_reg;
                clip  <= mute ? 1'b0 : clip_int;
            end
        end
    end

endmodule

// File: doc/audio_post.md
AUDIO_POST -- requirements
Module: audio_post

Interface
REQ-001 SHALL have parameter DIV, default 1024, meaning clk_sys cycles per output sample (legal range 1..65536).
REQ-002 SHALL have parameter SHIFT, default 8, meaning the DC-blocker pole shift (legal range 1..15).
REQ-003 SHALL have port clk_sys  input  1  single system clock; all state on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port sound_mix  input  19  mixed audio from the sound board, two's-complement signed.
REQ-006 SHALL have port vol  input  2  gain select: 0 = x1/8, 1 = x1/4, 2 = x1/2, 3 = x1.
REQ-007 SHALL have port mute  input  1  forces the audio outputs to zero when high.
REQ-008 SHALL have port sample  output  1  one-cycle strobe marking new aud_l/aud_r values.
REQ-009 SHALL have port aud_l  output  16  signed left-channel sample.
REQ-010 SHALL have port aud_r  output  16  signed right-channel sample, always equal to aud_l.
REQ-011 SHALL have port clip  output  1  high with sample when the emitted value was saturated.

Function
REQ-012 SHALL hold a divider counter cnt (0..DIV-1) that increments every cycle and wraps to 0 after DIV-1.
REQ-013 SHALL assert internal tick for one cycle when cnt == DIV-1; with DIV=1, tick SHALL be high every cycle.
REQ-014 SHALL sample sound_mix only on tick cycles; sound_mix is ignored on all other cycles.
REQ-015 Stage 1, on tick, SHALL compute y = x - x_prev + y_prev - (y_prev >>> SHIFT) in 24-bit signed arithmetic (x sign-extended), then store x_prev <= x and y_prev <= y.
REQ-016 SHALL saturate y to [-2^23, 2^23-1] before storing it; it SHALL never wrap.
REQ-017 Stage 2, one cycle after tick, SHALL compute s = y_prev >>> (3 - vol), an arithmetic shift using vol as sampled in that cycle.
REQ-018 Stage 2 SHALL saturate s to [-32768, 32767] and set clip_int = 1 iff saturation changed the value.
REQ-019 Stage 3, two cycles after tick, SHALL register aud_l = aud_r = (mute ? 0 : saturated s), clip = (mute ? 0 : clip_int), and sample = 1.
REQ-020 Latency: a tick at cycle t SHALL produce sample = 1 and updated outputs at cycle t+2; sample SHALL be low on every other cycle.
REQ-021 aud_l, aud_r and clip SHALL hold their values between sample strobes.
REQ-022 mute SHALL not stop the filter state from updating; the next unmuted sample SHALL reflect the continuous filter history.
REQ-023 vol and mute changing mid-pipeline SHALL take effect at the stage that samples them (REQ-017, REQ-019), with no glitch on the outputs between strobes.

Reset
REQ-024 While reset is high, cnt, x_prev, y_prev, the pipeline registers, aud_l, aud_r, sample and clip SHALL all be 0, asynchronously.
REQ-025 Reset asserted mid-pipeline SHALL discard any in-flight sample; no sample strobe SHALL follow from it.
REQ-026 After reset deasserts, the first tick SHALL occur DIV-1 cycles later, counting the first active edge as cycle 0.

Verification
REQ-027 DC step: DIV=4, SHIFT=8, vol=3, sound_mix=1000 constant -> sample at cycles 5, 9, 13, ...; aud_l = 1000, then 997, then monotonically decaying toward 0; clip = 0.
REQ-028 Positive saturation: vol=3, first tick with sound_mix=262143 -> aud_l = aud_r = 32767 and clip = 1 with the strobe.
REQ-029 Negative saturation: vol=3, first tick with sound_mix=19'h40000 (-262144) -> aud_l = -32768 and clip = 1.
REQ-030 Gain: vol=0, first tick with sound_mix=800 -> aud_l = 100, clip = 0; repeat with vol=2 -> aud_l = 400.
REQ-031 Mute: mute=1, sound_mix=1000 -> strobes continue with aud_l = 0 and clip = 0; release mute on the 2nd sample -> aud_l = 994 (the filter continued).
REQ-032 Reset mid-op: assert reset one cycle after a tick -> no strobe follows, all outputs read 0 immediately, and the next strobe comes DIV+1 cycles after reset deasserts.
